sdio_addr_ctlr_p: RTL
=====================

Name: sdio_addr_ctlr_p

Overview:
Parametrised next-generation SDIO address controller. Builds an AWIDTH-bit address from DWIDTH-wide bus writes, one bank per write, and auto-advances it per access. Compared with the fixed 17-bit controller it adds a single-clock synchronous design, configurable widths, a linear or wrap-window increment mode, and a block-length counter with a terminal-count stop. It sits between the host bus interface and the SDIO register/FIFO address decode.

Parameters:
AWIDTH, 17, address width in bits
DWIDTH, 8, host data bus width in bits
BSWIDTH, 3, bank select width; NBANKS = ceil(AWIDTH/DWIDTH) must be <= 2^BSWIDTH-1
CWIDTH, 8, block counter width; must be <= DWIDTH
WRAP_LOG2, 4, wrap window size = 2^WRAP_LOG2 addresses; must be < AWIDTH
SYNC_STAGES, 2, synchroniser depth for ACTL_StrbN; must be >= 2

Ports:
ACTL_Clk  in  1  system clock; all state changes on its rising edge
ACTL_Rst  in  1  synchronous, active-high reset
ACTL_StrbN  in  1  asynchronous host strobe; a rising edge triggers one event
ACTL_CmdN  in  1  0 = command mode, event ignored; 1 = data mode
ACTL_Data_In  in  DWIDTH  load data
ACTL_BSel  in  BSWIDTH  bank select; all-ones selects the counter
ACTL_Inc  in  1  advance address on this event
ACTL_Mode  in  2  00 hold, 01 linear, 10 wrap, 11 reserved (treated as hold)
ACTL_Addr_Out  out  AWIDTH  current address
ACTL_Cnt_Out  out  CWIDTH  remaining block count
ACTL_TC  out  1  terminal count reached; sticky
ACTL_Ack  out  1  one-cycle pulse on the update edge for every processed event

Behaviour:
- Clock and reset: one clock, ACTL_Clk. Reset ACTL_Rst is synchronous and active-high.
- Reset values: Addr_Out=0, Cnt_Out=0, TC=0, Ack=0. The synchroniser flops are preset to 1 so no false edge follows reset.
- Reset mid-operation: reset wins over any event in the same cycle. A strobe edge already in the synchroniser is discarded.
- Strobe path: StrbN passes through SYNC_STAGES flops, then a rising-edge detect.
- Latency: the update occurs on clock edge SYNC_STAGES+1 after the first clock that samples StrbN high. Ack is asserted on the same edge.
- Input timing: Data_In, BSel, Inc, CmdN and Mode are sampled on the update edge. The host holds them stable from the StrbN rise until then. StrbN high and low times are each >= SYNC_STAGES+1 clocks.
- Command mode: event with CmdN=0 changes no state, but Ack still pulses.
- Address bank load: BSel=b with b < NBANKS writes Addr_Out[min(AWIDTH-1,(b+1)*DWIDTH-1) : b*DWIDTH] from the low bits of Data_In. BSel values >= NBANKS other than all-ones load nothing.
- Counter load: BSel=all-ones sets Cnt_Out = Data_In[CWIDTH-1:0] and clears TC.
- Advance eligibility: the address advances only when Inc=1, Mode is 01 or 10, and TC=0.
  - Linear (01): Addr+1 modulo 2^AWIDTH; all-ones wraps to 0.
  - Wrap (10): the low WRAP_LOG2 bits increment modulo 2^WRAP_LOG2; upper bits are unchanged.
- Counter per advance:
  - Cnt_Out=0 means unlimited; no decrement, TC stays 0.
  - Cnt_Out>1: decrement.
  - Cnt_Out=1: advance, set Cnt_Out=0 and TC=1.
- After TC=1, further Inc events do not move the address or the counter. TC clears only on counter load or reset.
- Load and Inc in the same event:
  - The advanced address is computed first, then the selected bank field is overwritten with Data_In.
  - A counter load combined with Inc: the load wins, there is no decrement, and the address advances using the pre-load TC state.
- Hold mode (00 or 11) with Inc=1: the address holds, the counter does not decrement, and loads still apply.

Test Plan:
- Reset, then 3 strobes, CmdN=1, Inc=0, BSel=0/1/2, Data=0x34/0x12/0x01 -> Addr=0x11234; one Ack per strobe, each SYNC_STAGES+1 clocks after StrbN rise.
- Addr=0x1FFFF, Mode=01, Inc=1, Cnt=0 -> Addr=0x00000, TC=0.
- Addr=0x0012F, Mode=10, WRAP_LOG2=4, Inc strobe -> Addr=0x00120.
- Load Cnt=3, then 5 Inc strobes in Mode=01 from Addr=0x100 -> Addr=0x103, Cnt=0, TC=1 after the 3rd strobe; strobes 4-5 leave Addr unchanged.
- Strobe with CmdN=0, BSel=0, Data=0xFF, Inc=1 -> Addr and Cnt unchanged, Ack pulses; then assert Rst while a strobe is mid-synchroniser -> all outputs 0, no Ack.
- Addr=0x000FF, BSel=0, Data=0x10, Inc=1, Mode=01 -> Addr=0x00110 (increment carry kept, low bank overwritten).

Source files
------------

// File: rtl/sdio_addr_ctlr_p_if.sv
// Host-side bus bundle for the SDIO address controller.
// The host drives the strobe, mode and load fields; the controller returns
// the live address, the remaining block count, the terminal-count flag and the ack.
interface sdio_addr_ctlr_p_if #(
  parameter int AWIDTH  = 17,
  parameter int DWIDTH  = 8,
  parameter int BSWIDTH = 3,
  parameter int CWIDTH  = 8
);
  logic               ACTL_StrbN;
  logic               ACTL_CmdN;
  logic [DWIDTH-1:0]  ACTL_Data_In;
  logic [BSWIDTH-1:0] ACTL_BSel;
  logic               ACTL_Inc;
  logic [1:0]         ACTL_Mode;
  logic [AWIDTH-1:0]  ACTL_Addr_Out;
  logic [CWIDTH-1:0]  ACTL_Cnt_Out;
  logic               ACTL_TC;
  logic               ACTL_Ack;

  modport master (
    output ACTL_StrbN, ACTL_CmdN, ACTL_Data_In, ACTL_BSel, ACTL_Inc, ACTL_Mode,
    input  ACTL_Addr_Out, ACTL_Cnt_Out, ACTL_TC, ACTL_Ack
  );

  modport slave (
    input  ACTL_StrbN, ACTL_CmdN, ACTL_Data_In, ACTL_BSel, ACTL_Inc, ACTL_Mode,
    output ACTL_Addr_Out, ACTL_Cnt_Out, ACTL_TC, ACTL_Ack
  );
endinterface

// File: rtl/sdio_addr_ctlr_p.sv
// Parametrised SDIO address controller.
// An asynchronous host strobe is synchronised into the single clock domain and
// its rising edge triggers one event. An event can load one address bank or the
// block counter, and can advance the address linearly or inside a wrap window.
// Once the block counter runs out, the terminal-count flag freezes both the
// address and the counter until the counter is reloaded.
module sdio_addr_ctlr_p #(
  parameter int AWIDTH      = 17,
  parameter int DWIDTH      = 8,
  parameter int BSWIDTH     = 3,
  parameter int CWIDTH      = 8,
  parameter int WRAP_LOG2   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               ACTL_Clk,
  input  logic               ACTL_Rst,
  sdio_addr_ctlr_p_if.slave  bus
);

  localparam logic [BSWIDTH-1:0] CNT_SEL = '1;

  logic [SYNC_STAGES-1:0] strb_sync;
  logic                   strb_prev;
  logic                   strb_rise;

  logic [AWIDTH-1:0]      addr_q;
  logic [AWIDTH-1:0]      addr_adv;
  logic [AWIDTH-1:0]      addr_nxt;
  logic [CWIDTH-1:0]      cnt_q;
  logic                   tc_q;
  logic                   ack_q;
  logic                   advance;
  logic                   cnt_load;

  // Strobe synchroniser; preset high so that leaving reset never looks like a rising edge
  always_ff @(posedge ACTL_Clk) begin
    if (ACTL_Rst) begin
      strb_sync <= '1;
      strb_prev <= 1'b1;
    end else begin
      strb_sync <= {strb_sync[SYNC_STAGES-2:0], bus.ACTL_StrbN};
      strb_prev <= strb_sync[SYNC_STAGES-1];
    end
  end

  assign strb_rise = strb_sync[SYNC_STAGES-1] & ~strb_prev;

  // Next address: the advanced value first, then the selected bank overwrites its field
  always_comb begin
    advance  = bus.ACTL_CmdN && bus.ACTL_Inc && !tc_q &&
               (bus.ACTL_Mode == 2'b01 || bus.ACTL_Mode == 2'b10);
    cnt_load = (bus.ACTL_BSel == CNT_SEL);
    addr_adv = addr_q;
    if (advance) begin
      if (bus.ACTL_Mode == 2'b01) begin
        addr_adv = addr_q + AWIDTH'(1);
      end else begin
        addr_adv[WRAP_LOG2-1:0] = addr_q[WRAP_LOG2-1:0] + WRAP_LOG2'(1);
      end
    end
    addr_nxt = addr_adv;
    for (int i = 0; i < AWIDTH; i++) begin
      if (int'(bus.ACTL_BSel) == i / DWIDTH) begin
        addr_nxt[i] = bus.ACTL_Data_In[i % DWIDTH];
      end
    end
  end

  // Event update: address, block counter, sticky terminal count and the ack pulse
  always_ff @(posedge ACTL_Clk) begin
    if (ACTL_Rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= strb_rise;
      if (strb_rise && bus.ACTL_CmdN) begin
        addr_q <= addr_nxt;
        if (cnt_load) begin
          cnt_q <= bus.ACTL_Data_In[CWIDTH-1:0];
          tc_q  <= 1'b0;
        end else if (advance && cnt_q != '0) begin
          if (cnt_q == CWIDTH'(1)) begin
            cnt_q <= '0;
            tc_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CWIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.ACTL_Addr_Out = addr_q;
  assign bus.ACTL_Cnt_Out  = cnt_q;
  assign bus.ACTL_TC       = tc_q;
  assign bus.ACTL_Ack      = ack_q;

endmodule
